// File: rtl/uart_mmio_responder_pkg.sv
// Shared constants for the uart_mmio_responder console device:
// register offsets, STATUS bit positions, RX-empty code and RX FSM encodings.
package uart_mmio_responder_pkg;

    localparam logic [1:0] UART_DATA_OFF   = 2'd0;
    localparam logic [1:0] UART_STATUS_OFF = 2'd1;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_VALID = 2;
    localparam int STAT_TX_OVF   = 3;

    localparam logic [7:0] RX_EMPTY_CODE = 8'hFF;

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_POLL = 2'd1;
    localparam logic [1:0] RX_WAIT = 2'd2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO for the console TX path; binary pointers with one
// extra wrap bit. Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// Memory-mapped console: DATA stores feed the harness UART, DATA loads return polled RX bytes.
// Optional UART_LOOPBACK_EN routes drained TX bytes into the RX holding register instead of polling.
//
// state   | meaning
// RX_IDLE | holding register full, or about to poll
// RX_POLL | uart_in_valid_o high, harness reply sampled this cycle
// RX_WAIT | backoff after an empty poll
module uart_mmio_responder
    import uart_mmio_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h1FE0_01E0,
    parameter int          TX_DEPTH      = 8,
    parameter int          POLL_INTERVAL = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        uart_out_valid_o,
    output logic [7:0]  uart_out_ch_o,
    output logic        uart_in_valid_o,
    input  logic [7:0]  uart_in_ch_i
);

    localparam int CNT_W = $clog2(POLL_INTERVAL + 1);
    localparam int CW    = $clog2(TX_DEPTH) + 1;

    logic             hit;
    logic             ld;
    logic             st;
    logic [1:0]       off;
    logic             tx_push_req;
    logic             tx_drain;
    logic             tx_full;
    logic             tx_empty;
    logic [CW-1:0]    tx_count;
    logic [7:0]       tx_rdata;
    logic             tx_ovf;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             rx_pop;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       status;
    logic             unused_bits;

    assign unused_bits = ^{addr_i[1:0], sel_i[3:1], data_i[31:8], uart_in_ch_i};

    assign hit         = ce_i && (addr_i[31:4] == BASE_ADDR[31:4]);
    assign off         = addr_i[3:2];
    assign ld          = hit && !we_i;
    assign st          = hit && we_i;
    assign tx_push_req = st && (off == UART_DATA_OFF) && sel_i[0];
    assign rx_pop      = ld && (off == UART_DATA_OFF) && rx_valid;

`ifdef UART_LOOPBACK_EN
    assign tx_drain        = (tx_count != '0) && !rx_valid;
    assign uart_in_valid_o = 1'b0;
`else
    assign tx_drain        = (tx_count != '0);
    assign uart_in_valid_o = (rx_state == RX_POLL);
`endif

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push_req),
        .pop   (tx_drain),
        .wdata (data_i[7:0]),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_comb begin
        status                = '0;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_RX_VALID] = rx_valid;
        status[STAT_TX_OVF]   = tx_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_out_valid_o <= 1'b0;
            uart_out_ch_o    <= 8'h00;
        end else begin
            uart_out_valid_o <= tx_drain;
            if (tx_drain) uart_out_ch_o <= tx_rdata;
        end
    end

    // A dropped push wins over a STATUS read clearing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf <= 1'b0;
        end else begin
            if (ld && (off == UART_STATUS_OFF)) tx_ovf <= 1'b0;
            if (tx_push_req && tx_full)         tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o <= '0;
        end else if (ld) begin
            case (off)
                UART_DATA_OFF:   data_o <= {24'b0, rx_valid ? rx_byte : RX_EMPTY_CODE};
                UART_STATUS_OFF: data_o <= {28'b0, status};
                default:         data_o <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= 8'h00;
        end else begin
            if (rx_pop) rx_valid <= 1'b0;
`ifdef UART_LOOPBACK_EN
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            if (tx_drain) begin
                rx_byte  <= tx_rdata;
                rx_valid <= 1'b1;
            end
`else
            case (rx_state)
                RX_IDLE: if (!rx_valid) rx_state <= RX_POLL;
                RX_POLL: begin
                    if (uart_in_ch_i != RX_EMPTY_CODE) begin
                        rx_byte  <= uart_in_ch_i;
                        rx_valid <= 1'b1;
                        rx_state <= RX_IDLE;
                    end else if (POLL_INTERVAL == 1) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt   <= CNT_W'(POLL_INTERVAL - 1);
                        rx_state <= RX_WAIT;
                    end
                end
                // Leaving on count 1 gives POLL_INTERVAL idle cycles including the IDLE hop.
                RX_WAIT: begin
                    rx_cnt <= rx_cnt - 1'b1;
                    if (rx_cnt <= CNT_W'(1)) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
`endif
        end
    end

endmodule
